router_nlane_sched: RTL
=======================

Name: router_nlane_sched

Overview:
- Parametrised successor to the fixed 4-lane router front end.
- Accepts transfer requests (source/destination BRAM word address) through a valid/ready port and buffers them in a request FIFO.
- Dispatches each request to one of NUM_LANES lane engines using round-robin, then tracks per-lane completion.
- Sits between the host-side start/done interface and the per-lane arbiter/BRAM movers.

Parameters:
- NUM_LANES, 4, number of lane engines (2..16).
- ADDR_W, 10, width of source and destination addresses.
- FIFO_DEPTH, 8, request FIFO entries (power of two, >=2).
- TIMEOUT_CYCLES, 1024, lane watchdog limit; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- router_start_req  in  1  request valid.
- router_start_ready  out  1  request FIFO not full.
- router_scr_addr  in  ADDR_W  request source address.
- router_dst_addr  in  ADDR_W  request destination address.
- lane_start  out  NUM_LANES  one-cycle start pulse per lane.
- lane_scr_addr  out  NUM_LANES*ADDR_W  per-lane source address; lane i occupies bits [i*ADDR_W +: ADDR_W].
- lane_dst_addr  out  NUM_LANES*ADDR_W  per-lane destination address, same packing.
- lane_done  in  NUM_LANES  per-lane completion pulse from the mover.
- xfer_done  out  NUM_LANES  one-cycle pulse per lane on completion.
- router_done  out  1  level: FIFO empty and all lanes IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (rst sampled high at posedge):
  - lane_start, xfer_done, lane_*_addr, fifo_count = 0.
  - router_done = 1; router_start_ready = 1.
  - All lanes IDLE; round-robin pointer = lane 0 (highest priority).
- Reset asserted mid-operation:
  - Discards FIFO contents and aborts all lanes without issuing xfer_done.
  - lane_done pulses arriving during or after reset for aborted work are ignored.
- Request port:
  - A push occurs when router_start_req & router_start_ready at posedge.
  - Ready is low when count == FIFO_DEPTH. There is no bypass; a full FIFO accepts nothing.
  - Push and pop in the same cycle are both allowed; count is unchanged.
- Dispatch:
  - Each cycle, if the FIFO is non-empty and at least one lane is IDLE, pop the head.
  - The target is the first IDLE lane at or after the RR pointer, with wrap-around.
  - The RR pointer then moves to target+1 mod NUM_LANES.
  - At most one dispatch per cycle.
- Lane FSM, per lane:
  - IDLE -> START on dispatch; addresses are latched into lane_*_addr[i].
  - START: lane_start[i] = 1 for exactly one cycle -> WAIT.
  - WAIT -> IDLE when lane_done[i] = 1; xfer_done[i] pulses in the same cycle as the IDLE transition.
  - lane_done[i] in IDLE or START is ignored.
  - A lane returning to IDLE is eligible for dispatch on the following posedge, not the same one.
- Latency:
  - Request accepted at edge E0 with FIFO empty and a lane idle -> pop at E1 -> lane_start high in cycle E1..E2.
  - Minimum request-to-lane_start latency is 1 cycle after the accept edge.
- Simultaneous lane_done on several lanes: each is handled independently; xfer_done can be multi-hot.
- router_done:
  - Registered; falls the cycle after the first push.
  - Rises the cycle after the final lane returns to IDLE with the FIFO empty.
- lane_*_addr hold their last value in IDLE.

Optional Feature:
- Macro: ROUTER_TIMEOUT_EN.
- Defined:
  - Adds a per-lane counter, cleared on entry to WAIT and incremented each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES without lane_done, the lane goes to IDLE.
  - Sets sticky output lane_timeout[NUM_LANES] bit i; cleared only by rst.
  - No xfer_done is issued for a timed-out transfer.
- Undefined: the lane_timeout port and the counters are absent; WAIT holds indefinitely.

Decomposition:
- Package router_nlane_pkg:
  - lane_state_e (IDLE, START, WAIT).
  - req_t struct {scr_addr, dst_addr}, parametrised via a localparam ADDR_W default.
  - Function for the round-robin next-index calculation.
- Sub-module router_req_fifo: synchronous FIFO of req_t with count, full and empty.
- Lane FSMs are a generate loop in the top module.

Test Plan:
- Single request src=0x001, dst=0x005 after reset:
  - lane_start[0] pulses 1 cycle after accept with lane_scr_addr[0]=0x001, lane_dst_addr[0]=0x005.
  - After lane_done[0] pulses: xfer_done[0] pulses and router_done returns to 1.
- Five back-to-back requests (0x0->0x9, 0x1->0x5, 0x2->0xF, 0x3->0x5, 0x4->0x9) with lanes held busy:
  - Lanes 0,1,2,3 start in consecutive cycles.
  - Fifth request waits; it starts on lane 0 one cycle after lane_done[0].
- Fill FIFO with 8 requests while all lanes are busy:
  - router_start_ready = 0 and fifo_count = 8.
  - A 9th request held valid is accepted only after the first pop.
- lane_done[1] and lane_done[3] asserted in the same cycle: xfer_done = 4'b1010 that cycle.
- rst pulsed while 3 lanes are in WAIT and the FIFO holds 2 entries:
  - Next cycle fifo_count = 0, router_done = 1, no xfer_done.
  - A later lane_done is ignored.
- ROUTER_TIMEOUT_EN with TIMEOUT_CYCLES=16 and lane 2 never responding:
  - lane_timeout[2] sets 16 cycles after entering WAIT.
  - Lane 2 accepts the next dispatch.

Source files
------------

// File: rtl/router_nlane_pkg.sv
// router_nlane_pkg: shared lane state encoding, request record and round-robin helper
// for the N-lane request router.
package router_nlane_pkg;

    // Default address width of the request record. The top module re-declares the
    // record at its own ADDR_W and hands it to the FIFO as a type parameter.
    localparam int DEF_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } lane_state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] scr_addr;
        logic [DEF_ADDR_W-1:0] dst_addr;
    } req_t;

    // Next lane index after idx, wrapping at n. Also works when n is not a power of two.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/router_req_fifo.sv
// router_req_fifo: synchronous request FIFO with occupancy count and full/empty flags.
// A push is refused when full and a pop is refused when empty. There is no bypass
// path, so data pushed at an edge can be popped at the next edge at the earliest.
module router_req_fifo
    import router_nlane_pkg::*;
#(
    parameter type T     = req_t,
    parameter int  DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       din,
    input  logic                   pop,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_nxt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign dout      = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign count_nxt = count_d;

    // Next storage contents, pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset discards all queued requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/router_nlane_sched.sv
// router_nlane_sched: request FIFO front end that dispatches transfers round-robin to
// NUM_LANES lane engines and tracks each lane through start and completion.
//
// Optional build macro ROUTER_TIMEOUT_EN adds a per-lane WAIT watchdog and the sticky
// lane_timeout output. Without it, a lane waits for lane_done indefinitely.
//
// Lane FSM:
//   state | meaning
//   IDLE  | free; may be picked by the dispatcher, addresses hold their last value
//   START | lane_start pulse is on the output for this one cycle
//   WAIT  | mover busy; lane_done returns the lane to IDLE with an xfer_done pulse
module router_nlane_sched
    import router_nlane_pkg::*;
#(
    parameter int NUM_LANES      = 4,
    parameter int ADDR_W         = 10,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          router_start_req,
    output logic                          router_start_ready,
    input  logic [ADDR_W-1:0]             router_scr_addr,
    input  logic [ADDR_W-1:0]             router_dst_addr,
    output logic [NUM_LANES-1:0]          lane_start,
    output logic [NUM_LANES*ADDR_W-1:0]   lane_scr_addr,
    output logic [NUM_LANES*ADDR_W-1:0]   lane_dst_addr,
    input  logic [NUM_LANES-1:0]          lane_done,
    output logic [NUM_LANES-1:0]          xfer_done,
    output logic                          router_done,
`ifdef ROUTER_TIMEOUT_EN
    output logic [NUM_LANES-1:0]          lane_timeout,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
`ifdef ROUTER_TIMEOUT_EN
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
`endif

    // Reject configurations the lane index and FIFO pointer arithmetic cannot handle.
    if (NUM_LANES < 2 || NUM_LANES > 16 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("router_nlane_sched: unsupported parameter set");
    end

    // Request record at this instance's address width.
    typedef struct packed {
        logic [ADDR_W-1:0] scr_addr;
        logic [ADDR_W-1:0] dst_addr;
    } lane_req_t;

    lane_req_t            fifo_din, fifo_dout;
    logic                 fifo_full, fifo_empty;
    logic [CNT_W-1:0]     fifo_count_nxt;
    logic                 push, pop;

    logic [NUM_LANES-1:0] lane_idle;
    logic [NUM_LANES-1:0] lane_idle_nxt;
    logic                 disp_found;
    logic [LANE_W-1:0]    disp_lane;
    logic [LANE_W-1:0]    rr_q, rr_d;
    logic                 router_done_q, router_done_d;

    assign fifo_din           = '{scr_addr: router_scr_addr, dst_addr: router_dst_addr};
    assign router_start_ready = ~fifo_full;
    assign push               = router_start_req & router_start_ready;
    assign pop                = disp_found & ~fifo_empty;
    assign router_done        = router_done_q;

    router_req_fifo #(
        .T     (lane_req_t),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .din       (fifo_din),
        .pop       (pop),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .count_nxt (fifo_count_nxt)
    );

    // Pick the first lane that is IDLE now, scanning from the round-robin pointer with wrap.
    // A lane that only becomes IDLE at this edge is not visible here until the next cycle.
    always_comb begin
        logic [LANE_W-1:0] cur;
        cur        = rr_q;
        disp_found = 1'b0;
        disp_lane  = rr_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!disp_found && lane_idle[cur]) begin
                disp_found = 1'b1;
                disp_lane  = cur;
            end
            cur = LANE_W'(rr_next(int'(cur), NUM_LANES));
        end
    end

    // Pointer advance past the served lane, and the registered all-quiet indication.
    always_comb begin
        rr_d          = pop ? LANE_W'(rr_next(int'(disp_lane), NUM_LANES)) : rr_q;
        router_done_d = (fifo_count_nxt == '0) && (&lane_idle_nxt);
    end

    // Round-robin pointer and router_done registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q          <= '0;
            router_done_q <= 1'b1;
        end else begin
            rr_q          <= rr_d;
            router_done_q <= router_done_d;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_state_e       state_q, state_d;
        logic              start_q, start_d;
        logic              xdone_q, xdone_d;
        logic [ADDR_W-1:0] scr_q, scr_d;
        logic [ADDR_W-1:0] dst_q, dst_d;
        logic              dispatch_here;
`ifdef ROUTER_TIMEOUT_EN
        logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
        logic              timeout_q, timeout_d;
`endif

        assign dispatch_here = pop && (disp_lane == LANE_W'(i));

        // Lane next state: latch addresses on dispatch, pulse start, then wait for the mover.
        always_comb begin
            state_d = state_q;
            start_d = 1'b0;
            xdone_d = 1'b0;
            scr_d   = scr_q;
            dst_d   = dst_q;
`ifdef ROUTER_TIMEOUT_EN
            wait_cnt_d = wait_cnt_q;
            timeout_d  = timeout_q;
`endif
            unique case (state_q)
                IDLE: begin
                    if (dispatch_here) begin
                        state_d = START;
                        start_d = 1'b1;
                        scr_d   = fifo_dout.scr_addr;
                        dst_d   = fifo_dout.dst_addr;
                    end
                end
                START: begin
                    state_d = WAIT;
`ifdef ROUTER_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
                WAIT: begin
                    if (lane_done[i]) begin
                        state_d = IDLE;
                        xdone_d = 1'b1;
                    end
`ifdef ROUTER_TIMEOUT_EN
                    else if (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end

        // Lane registers; reset aborts the transfer silently.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                start_q <= 1'b0;
                xdone_q <= 1'b0;
                scr_q   <= '0;
                dst_q   <= '0;
            end else begin
                state_q <= state_d;
                start_q <= start_d;
                xdone_q <= xdone_d;
                scr_q   <= scr_d;
                dst_q   <= dst_d;
            end
        end

`ifdef ROUTER_TIMEOUT_EN
        // Watchdog counter and sticky timeout flag.
        always_ff @(posedge clk) begin
            if (rst) begin
                wait_cnt_q <= '0;
                timeout_q  <= 1'b0;
            end else begin
                wait_cnt_q <= wait_cnt_d;
                timeout_q  <= timeout_d;
            end
        end

        assign lane_timeout[i] = timeout_q;
`endif

        assign lane_idle[i]                       = (state_q == IDLE);
        assign lane_idle_nxt[i]                   = (state_d == IDLE);
        assign lane_start[i]                      = start_q;
        assign xfer_done[i]                       = xdone_q;
        assign lane_scr_addr[i*ADDR_W +: ADDR_W]  = scr_q;
        assign lane_dst_addr[i*ADDR_W +: ADDR_W]  = dst_q;
    end

endmodule
